mem_arbiter_2to1: RTL and testbench

//  Two-master to one-slave arbiter on the req/gnt/rvalid memory protocol. Sits directly

---
 rtl/soc_mem_pkg.sv | 17 +
 rtl/mem_arbiter_2to1_id_fifo.sv | 68 ++++++
 rtl/mem_arbiter_2to1.sv | 126 ++++++++++++
 tb/tb_mem_arbiter_2to1.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared master-ID type and constants for the memory arbiter slice.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package soc_mem_pkg;

  // One bit identifies which master issued a request.
  typedef logic mst_id_t;

  localparam mst_id_t MST_INSTR = 1'b0;
  localparam mst_id_t MST_DATA  = 1'b1;

  // The master that gets priority after `id` has been served.
  function automatic mst_id_t other_mst(input mst_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_2to1_id_fifo.sv
// In-order FIFO of issuer IDs, one entry per accepted-but-unanswered request.
// Latency: head is combinational from storage; push is visible on the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not fill the pointer's binary range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Round-robin 2:1 arbiter (instr/data) in front of the single-port RAM; routes responses by issuer.
// Latency: request fields and gnt are combinational (0 cycles); rvalid tracks the RAM's latency.
// Backpressure: s_req_o drops while MAX_OUTSTANDING responses are pending, unless one returns this cycle.
module mem_arbiter_2to1 #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i
);

  import soc_mem_pkg::*;

  mst_id_t prio;        // master that wins a tie
  mst_id_t sel;         // master whose request is presented to the RAM
  mst_id_t head_id;     // issuer of the oldest outstanding request
  logic    any_req;
  logic    can_push;
  logic    accept;
  logic    pop;
  logic    fifo_full;
  logic    fifo_empty;

  // Winner selection: a lone requester wins, a tie goes to prio, idle presents master 0.
  always_comb begin
    sel = MST_INSTR;
    if (m0_req_i && m1_req_i) begin
      sel = prio;
    end else if (m1_req_i) begin
      sel = MST_DATA;
    end
  end

  // A returning response frees its ID slot in the same cycle, so full + rvalid can still issue.
  assign any_req  = m0_req_i | m1_req_i;
  assign can_push = ~fifo_full | s_rvalid_i;
  assign s_req_o  = rst_n & any_req & can_push;
  assign accept   = s_req_o & s_gnt_i;

  // gnt mirrors the RAM's same-cycle gnt, steered to the selected master only.
  assign m0_gnt_o = accept & (sel == MST_INSTR);
  assign m1_gnt_o = accept & (sel == MST_DATA);

  // Request field mux; purely combinational so the RAM sees no added latency.
  always_comb begin
    s_addr_o  = m0_addr_i;
    s_we_o    = m0_we_i;
    s_wdata_o = m0_wdata_i;
    s_be_o    = m0_be_i;
    if (sel == MST_DATA) begin
      s_addr_o  = m1_addr_i;
      s_we_o    = m1_we_i;
      s_wdata_o = m1_wdata_i;
      s_be_o    = m1_be_i;
    end
  end

  // Responses go to the issuer at the FIFO head; a response with nothing outstanding is dropped.
  assign pop         = rst_n & s_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = pop & (head_id == MST_INSTR);
  assign m1_rvalid_o = pop & (head_id == MST_DATA);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  // Round-robin pointer moves only when a request is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= MST_INSTR;
    end else if (accept) begin
      prio <= other_mst(sel);
    end
  end

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (sel),
    .pop      (pop),
    .head     (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifndef SYNTHESIS
  // Protocol check: the RAM must never answer when no request is outstanding.
  always_ff @(posedge clk) begin
    if (rst_n && s_rvalid_i) begin
      assert (!fifo_empty)
        else $warning("mem_arbiter_2to1: rvalid with no outstanding request, response dropped");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter_2to1;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } rq_t;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  typedef struct {
    logic          id;
    logic          rd;
    logic [DW-1:0] d;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_req, m1_req;
  rq_t           cur0, cur1;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_we, m1_we;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [BW-1:0] m0_be, m1_be;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [BW-1:0] s_be;

  assign m0_addr  = cur0.addr;
  assign m0_we    = cur0.we;
  assign m0_wdata = cur0.wdata;
  assign m0_be    = cur0.be;
  assign m1_addr  = cur1.addr;
  assign m1_we    = cur1.we;
  assign m1_wdata = cur1.wdata;
  assign m1_be    = cur1.be;

  mem_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | (i * 32'h0000_0101);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic rq_t mk(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                             input logic [BW-1:0] be);
    rq_t r;
    r.addr = a; r.we = we; r.wdata = d; r.be = be;
    return r;
  endfunction

  // ---------------- behavioural reference model + compare ----------------
  out_t          oq[$];
  logic          last_w;
  logic [DW-1:0] gmem [64];
  bit            run_chk = 0;

  always @(negedge clk) begin : cmp
    logic          w, room, pop, acc, any, mwe;
    logic [AW-1:0] ma;
    out_t          e;
    if (run_chk) begin
      if (!rst_n) begin
        chk("s_req_o(reset)", s_req, 0);
        chk("gnt(reset)", {m1_gnt, m0_gnt}, 0);
        chk("rvalid(reset)", {m1_rvalid, m0_rvalid}, 0);
        oq.delete();
        last_w = 1'b1;
      end else begin
        any  = m0_req | m1_req;
        w    = (m0_req && m1_req) ? ~last_w : m1_req;
        room = (oq.size() < MAXO) || s_rvalid;
        pop  = s_rvalid && (oq.size() > 0);
        acc  = any && room && s_gnt;
        chk("s_req_o", s_req, any && room);
        chk("m0_gnt_o", m0_gnt, acc && !w);
        chk("m1_gnt_o", m1_gnt, acc && w);
        chk("s_fields", {s_addr, s_we, s_wdata, s_be},
            w ? {m1_addr, m1_we, m1_wdata, m1_be} : {m0_addr, m0_we, m0_wdata, m0_be});
        chk("m0_rvalid_o", m0_rvalid, pop && (oq[0].id == 1'b0));
        chk("m1_rvalid_o", m1_rvalid, pop && (oq[0].id == 1'b1));
        if (pop && oq[0].rd)
          chk(oq[0].id ? "m1_rdata_o" : "m0_rdata_o", oq[0].id ? m1_rdata : m0_rdata, oq[0].d);
        if (pop) void'(oq.pop_front());
        if (acc) begin
          ma   = w ? m1_addr : m0_addr;
          mwe  = w ? m1_we : m0_we;
          e.id = w;
          e.rd = !mwe;
          e.d  = gmem[ma[7:2]];
          if (mwe) gmem[ma[7:2]] = merge(gmem[ma[7:2]], w ? m1_wdata : m0_wdata, w ? m1_be : m0_be);
          oq.push_back(e);
          last_w = w;
        end
      end
    end
  end

  // ---------------- environment: masters and RAM slave ----------------
  rq_t           scr0[$], scr1[$];
  logic [DW-1:0] ram [64];
  rsp_t          pend[$];
  int            cyc = 0;
  int            gnt_pct = 100;
  int            lat_max = 1;
  bit            rv_hold = 0;
  bit            spur = 0;
  logic          g0_seen = 0, g1_seen = 0, rv0_seen, rv1_seen, sreq_seen;
  logic [DW-1:0] rd0_seen, rd1_seen;

  task automatic drive();
    rsp_t r;
    if (!m0_req || g0_seen) begin
      if (scr0.size() > 0) begin cur0 = scr0.pop_front(); m0_req = 1'b1; end
      else m0_req = 1'b0;
    end
    if (!m1_req || g1_seen) begin
      if (scr1.size() > 0) begin cur1 = scr1.pop_front(); m1_req = 1'b1; end
      else m1_req = 1'b0;
    end
    s_gnt = ($urandom_range(99) < gnt_pct);
    if (!rst_n) pend.delete();
    if (spur) begin
      s_rvalid = 1'b1; s_rdata = $urandom;
    end else if (rst_n && !rv_hold && pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      s_rvalid = 1'b1; s_rdata = r.d;
    end else begin
      s_rvalid = 1'b0; s_rdata = $urandom;
    end
  endtask

  task automatic step();
    rsp_t r;
    drive();
    @(negedge clk);
    g0_seen = m0_gnt; g1_seen = m1_gnt; rv0_seen = m0_rvalid; rv1_seen = m1_rvalid;
    rd0_seen = m0_rdata; rd1_seen = m1_rdata; sreq_seen = s_req;
    if (s_req && s_gnt) begin
      r.d   = ram[s_addr[7:2]];
      r.due = cyc + $urandom_range(1, lat_max);
      if (s_we) ram[s_addr[7:2]] = merge(ram[s_addr[7:2]], s_wdata, s_be);
      pend.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic bit idle();
    return !m0_req && !m1_req && scr0.size() == 0 && scr1.size() == 0 && pend.size() == 0;
  endfunction

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (idle()) break;
      step();
    end
    chk("drain_timeout", idle(), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int            gl, ng, nr, idx;
    logic [DW-1:0] rb [8];
    for (int i = 0; i < 64; i++) begin ram[i] = init_word(i); gmem[i] = init_word(i); end
    last_w   = 1'b1;
    rst_n    = 1'b0;
    s_gnt    = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    cur0     = mk(8'h00, 1'b0, '0, 4'hF);
    cur1     = mk(8'h40, 1'b0, '0, 4'hF);
    m0_req   = 1'b1; m1_req = 1'b1;
    for (int i = 1; i < 8; i++) begin
      scr0.push_back(mk(8'(4 * i), 1'b0, '0, 4'hF));
      scr1.push_back(mk(8'(8'h40 + 4 * i), 1'b0, '0, 4'hF));
    end
    run_chk = 1;

    // Reset held with both masters requesting: nothing leaves the arbiter.
    repeat (3) begin
      step();
      chk("reset_s_req", sreq_seen, 0);
      chk("reset_gnt", {g1_seen, g0_seen}, 0);
    end
    rst_n = 1'b1;

    // Contention: grants alternate starting with m0; responses routed with preload data.
    for (int k = 0; k < 8; k++) begin
      step();
      gl = g1_seen ? 1 : (g0_seen ? 0 : 2);
      chk("alt_grant", gl, k % 2);
      if (k == 1) begin
        chk("first_rsp_m0_rvalid", rv0_seen, 1);
        chk("first_rsp_m0_rdata", rd0_seen, 32'hC0DE_0000);
      end
      if (k == 2) begin
        chk("second_rsp_m1_rvalid", rv1_seen, 1);
        chk("second_rsp_m1_rdata", rd1_seen, 32'hC0DE_1010);
      end
    end
    drain();

    // Single master: m1 issues 8 back-to-back partial writes.
    for (int i = 0; i < 8; i++) scr1.push_back(mk(8'(4 * i), 1'b1, 32'h1122_3344 + i, 4'b0101));
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 8) chk("wr_burst_gnt", {g1_seen, g0_seen}, 2'b10);
      nr += int'(rv1_seen);
    end
    chk("wr_burst_rvalid_count", nr, 8);
    drain();
    for (int i = 0; i < 8; i++) scr1.push_back(mk(8'(4 * i), 1'b0, '0, 4'hF));
    idx = 0;
    for (int k = 0; k < 30 && idx < 8; k++) begin
      step();
      if (rv1_seen) begin rb[idx] = rd1_seen; idx++; end
    end
    chk("readback_count", idx, 8);
    for (int i = 0; i < 8; i++)
      chk("readback_bytes02", rb[i], (init_word(i) & 32'hFF00_FF00) | ((32'h1122_3344 + i) & 32'h00FF_00FF));
    drain();

    // Backpressure: responses stalled, only MAX_OUTSTANDING accepts.
    rv_hold = 1;
    for (int i = 0; i < 3; i++) scr0.push_back(mk(8'(8'h80 + 4 * i), 1'b0, '0, 4'hF));
    ng = 0;
    repeat (4) begin step(); ng += int'(g0_seen); end
    chk("stall_accepts", ng, 2);
    chk("stall_s_req", sreq_seen, 0);
    rv_hold = 0;
    step();
    chk("unstall_gnt_same_cycle", g0_seen, 1);
    chk("unstall_rvalid", rv0_seen, 1);
    drain();

    // Spurious response with nothing outstanding.
    spur = 1;
    step();
    spur = 0;
    chk("spurious_rvalid", {rv1_seen, rv0_seen}, 0);
    chk("spurious_count", dut.u_id_fifo.count, 0);

    // Reset with two requests outstanding.
    rv_hold = 1;
    scr0.push_back(mk(8'h90, 1'b0, '0, 4'hF));
    scr1.push_back(mk(8'hA0, 1'b0, '0, 4'hF));
    step(); step();
    chk("pre_reset_count", dut.u_id_fifo.count, 2);
    rst_n = 1'b0; rv_hold = 0;
    step(); step();
    chk("mid_reset_count", dut.u_id_fifo.count, 0);
    chk("mid_reset_prio", dut.prio, 0);
    rst_n = 1'b1;
    scr1.push_back(mk(8'hA4, 1'b0, '0, 4'hF));
    step();
    chk("post_reset_gnt", {g1_seen, g0_seen}, 2'b10);
    step();
    chk("post_reset_rvalid", {rv1_seen, rv0_seen}, 2'b10);
    chk("post_reset_rdata", rd1_seen, 32'hC0DE_2929);
    drain();

    // Randomized traffic: random gnt, latency, response stalls and one reset.
    gnt_pct = 75;
    lat_max = 3;
    for (int k = 0; k < 2000; k++) begin
      if (scr0.size() == 0 && $urandom_range(99) < 60)
        scr0.push_back(mk(8'($urandom_range(255)), ($urandom_range(99) < 30), $urandom, 4'($urandom_range(15))));
      if (scr1.size() == 0 && $urandom_range(99) < 60)
        scr1.push_back(mk(8'($urandom_range(255)), ($urandom_range(99) < 30), $urandom, 4'($urandom_range(15))));
      rv_hold = ($urandom_range(99) < 10);
      if (k == 1000) rst_n = 1'b0;
      if (k == 1002) rst_n = 1'b1;
      step();
    end
    rv_hold = 0;
    gnt_pct = 100;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
